sdram_cpu_bridge: RTL and testbench

- Upstream front-end for the SDRAM controller in the CP/M-80 system.
- Generates the free-running 3-bit slot phase (sdt) and the controller init pulse.
- Serialises 8-bit CPU byte reads and writes into one-slot controller accesses (word address, byte strobes, oe/we held for a full 8-phase slot).
- Captures read data at a fixed phase and returns it to the CPU with a one-cycle ack.

---
 rtl/sdram_cpu_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_cpu_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cpu_bridge.sv
// CPU byte-access front-end for the SDRAM controller: slot phase, init sequencing, one-slot accesses.
// Optional read/write access counters are built when SDRAM_BRIDGE_STATS_EN is defined.
module sdram_cpu_bridge #(
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned READ_PHASE   = 5,
  parameter int unsigned INIT_SLOTS   = 4,
  parameter int unsigned WARMUP_SLOTS = 32
) (
  input  logic              clk_hi,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_ready,
  output logic [2:0]        sdt,
  output logic              mem_init,
  output logic [23:0]       mem_addr,
  output logic [1:0]        mem_ds,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt
);

  localparam int unsigned MEM_AW    = 24;
  localparam int unsigned MAX_SLOTS = (INIT_SLOTS > WARMUP_SLOTS) ? INIT_SLOTS : WARMUP_SLOTS;
  localparam int unsigned CNT_W     = $clog2(MAX_SLOTS + 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_WARMUP,
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sdt_q, sdt_d;
  logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic              mem_init_q, mem_init_d;
  logic              mem_oe_q, mem_oe_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_ds_q, mem_ds_d;
  logic [15:0]       mem_din_q, mem_din_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;

  logic slot_end_c;
  logic accept_c;

  assign slot_end_c = (sdt_q == 3'd7);
  assign accept_c   = (state_q == ST_IDLE) && slot_end_c && cpu_req;

  always_ff @(posedge clk_hi or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sdt_q       <= 3'd0;
      slot_cnt_q  <= '0;
      mem_init_q  <= 1'b1;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_ds_q    <= 2'b00;
      mem_din_q   <= 16'h0000;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      cpu_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sdt_q       <= sdt_d;
      slot_cnt_q  <= slot_cnt_d;
      mem_init_q  <= mem_init_d;
      mem_oe_q    <= mem_oe_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_ds_q    <= mem_ds_d;
      mem_din_q   <= mem_din_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sdt_d       = sdt_q + 3'd1;
    slot_cnt_d  = slot_cnt_q;
    mem_init_d  = mem_init_q;
    mem_oe_d    = mem_oe_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_ds_d    = mem_ds_q;
    mem_din_d   = mem_din_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = cpu_ready_q;

    case (state_q)
      ST_INIT: begin
        if (slot_end_c) begin
          if (slot_cnt_q == CNT_W'(INIT_SLOTS - 1)) begin
            slot_cnt_d = '0;
            mem_init_d = 1'b0;
            state_d    = ST_WARMUP;
          end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WARMUP: begin
        if (slot_end_c) begin
          if (slot_cnt_q == CNT_W'(WARMUP_SLOTS - 1)) begin
            slot_cnt_d  = '0;
            cpu_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_IDLE: begin
        // Accepting only at a slot end leaves the following slot free for refresh.
        if (accept_c) begin
          mem_addr_d = MEM_AW'(cpu_addr[ADDR_W-1:1]);
          mem_ds_d   = cpu_addr[0] ? 2'b10 : 2'b01;
          mem_din_d  = {cpu_wdata, cpu_wdata};
          mem_we_d   = cpu_we;
          mem_oe_d   = ~cpu_we;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_oe_q && (sdt_q == 3'(READ_PHASE))) begin
          cpu_rdata_d = mem_ds_q[1] ? mem_dout[15:8] : mem_dout[7:0];
        end
        if (slot_end_c) begin
          mem_oe_d  = 1'b0;
          mem_we_d  = 1'b0;
          cpu_ack_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign sdt       = sdt_q;
  assign mem_init  = mem_init_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_ds    = mem_ds_q;
  assign mem_din   = mem_din_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;

`ifdef SDRAM_BRIDGE_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // Saturating access counters, stepped at request acceptance.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept_c) begin
      if (cpu_we) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_hi or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 16'h0000;
      wr_cnt_q <= 16'h0000;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign stat_rd_cnt = rd_cnt_q;
  assign stat_wr_cnt = wr_cnt_q;
`else
  assign stat_rd_cnt = 16'h0000;
  assign stat_wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Self-checking bench for sdram_cpu_bridge: table vectors, hand sequences and random accesses
// against a slot-timing model derived from the access rules.
module tb_sdram_cpu_bridge;

  localparam int INIT_T  = 4 * 8;
  localparam int READY_T = (4 + 32) * 8;

  logic        clk_hi;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_ready;
  logic [2:0]  sdt;
  logic        mem_init;
  logic [23:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_oe;
  logic        mem_we;
  logic [15:0] stat_rd_cnt;
  logic [15:0] stat_wr_cnt;

  sdram_cpu_bridge dut (
    .clk_hi      (clk_hi),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .cpu_ready   (cpu_ready),
    .sdt         (sdt),
    .mem_init    (mem_init),
    .mem_addr    (mem_addr),
    .mem_ds      (mem_ds),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_oe      (mem_oe),
    .mem_we      (mem_we),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
  );

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  wd;
    logic [15:0] dout;
    logic [23:0] e_addr;
    logic [1:0]  e_ds;
    logic [15:0] e_din;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t        vecs[6];
  int          n_pass;
  int          n_total;
  int          t;
  int          t_idle;
  int          n_rd;
  int          n_wr;
  logic [7:0]  last_rd;
  logic [15:0] rd_word;

  initial clk_hi = 1'b0;
  always #5 clk_hi = ~clk_hi;

  // Controller read model: the requested word is only present during the capture phase.
  always @(negedge clk_hi) mem_dout = (sdt == 3'd5) ? rd_word : ~rd_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, t);
  endtask

  task automatic tick();
    @(posedge clk_hi);
    #1;
    t++;
    check("sdt", 32'(sdt), 32'(t % 8));
    check("mem_init", 32'(mem_init), 32'(t < INIT_T));
    check("cpu_ready", 32'(cpu_ready), 32'(t >= READY_T));
  endtask

  function automatic logic [23:0] m_addr(input logic [24:0] a);
    return 24'(int'(a) / 2);
  endfunction

  function automatic logic [1:0] m_ds(input logic [24:0] a);
    return (int'(a) % 2 == 1) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [7:0] m_rd(input logic [24:0] a, input logic [15:0] d);
    return 8'((int'(d) >> (8 * (int'(a) % 2))) % 256);
  endfunction

  // One access: a request seen in IDLE is served in the slot after the next slot end.
  task automatic run_access(input logic we, input logic [24:0] addr, input logic [7:0] wd,
                            input logic [15:0] dout, input logic [23:0] e_addr,
                            input logic [1:0] e_ds, input logic [15:0] e_din,
                            input logic [7:0] e_rd, input int align, input bit keep);
    int tr;
    int st;
    if (align >= 0)
      for (int i = 0; i < 8 && (t % 8) != align; i++) tick();
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    rd_word   = dout;
    cpu_req   = 1'b1;
    tr = (t > t_idle) ? t : t_idle;
    st = tr + 8 - (tr % 8);
    if (we) n_wr++; else n_rd++;
    while (t < st + 8) begin
      tick();
      check("mem_oe", 32'(mem_oe), 32'(!we && t >= st && t < st + 8));
      check("mem_we", 32'(mem_we), 32'(we && t >= st && t < st + 8));
      check("cpu_ack", 32'(cpu_ack), 32'(t == st + 8));
      if (t == st || t == st + 7) begin
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_ds", 32'(mem_ds), 32'(e_ds));
        check("mem_din", 32'(mem_din), 32'(e_din));
      end
      if (t == st) begin
        cpu_addr  = 25'($urandom);
        cpu_wdata = 8'($urandom);
        cpu_we    = 1'($urandom);
      end
    end
    if (!we) last_rd = e_rd;
    check("cpu_rdata", 32'(cpu_rdata), 32'(last_rd));
    t_idle = t;
    if (!keep) begin
      cpu_req = 1'b0;
      tick();
      check("ack_width", 32'(cpu_ack), 32'd0);
    end
  endtask

  task automatic rand_access(input int align);
    logic        we;
    logic [24:0] a;
    logic [7:0]  wd;
    logic [15:0] d;
    we = 1'($urandom);
    a  = 25'($urandom);
    wd = 8'($urandom);
    d  = 16'($urandom);
    run_access(we, a, wd, d, m_addr(a), m_ds(a), {wd, wd}, m_rd(a, d), align, 1'b0);
  endtask

  task automatic check_stats(input string tag);
    int er;
    int ew;
`ifdef SDRAM_BRIDGE_STATS_EN
    er = (n_rd > 65535) ? 65535 : n_rd;
    ew = (n_wr > 65535) ? 65535 : n_wr;
`else
    er = 0;
    ew = 0;
`endif
    check({tag, "_rd"}, 32'(stat_rd_cnt), 32'(er));
    check({tag, "_wr"}, 32'(stat_wr_cnt), 32'(ew));
  endtask

  initial begin
    int st;
    n_pass = 0; n_total = 0; t = 0; t_idle = READY_T;
    n_rd = 0; n_wr = 0; last_rd = 8'h00; rd_word = 16'h0000;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;

    vecs[0] = '{1'b1, 25'h0000123, 8'h5A, 16'h0000, 24'h000091, 2'b10, 16'h5A5A, 8'h00};
    vecs[1] = '{1'b0, 25'h0000122, 8'h77, 16'hA55A, 24'h000091, 2'b01, 16'h7777, 8'h5A};
    vecs[2] = '{1'b0, 25'h0000123, 8'h77, 16'hA55A, 24'h000091, 2'b10, 16'h7777, 8'hA5};
    vecs[3] = '{1'b1, 25'h1FFFFFE, 8'hC3, 16'h0000, 24'hFFFFFF, 2'b01, 16'hC3C3, 8'h00};
    vecs[4] = '{1'b0, 25'h1FFFFFF, 8'h00, 16'h1234, 24'hFFFFFF, 2'b10, 16'h0000, 8'h12};
    vecs[5] = '{1'b1, 25'h0000000, 8'h00, 16'hFFFF, 24'h000000, 2'b01, 16'h0000, 8'h00};

    repeat (3) @(posedge clk_hi);
    #1;
    check("rst_sdt", 32'(sdt), 32'd0);
    check("rst_mem_init", 32'(mem_init), 32'd1);
    check("rst_oe_we", 32'({mem_oe, mem_we}), 32'd0);
    check("rst_addr_ds_din", 32'(mem_addr) | 32'(mem_ds) | 32'(mem_din), 32'd0);
    check("rst_ack_rdata", 32'({cpu_ack, cpu_rdata}), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check_stats("rst_stat");

    @(negedge clk_hi);
    rst = 1'b0;
    t = 0;

    // Request raised during warm-up waits for cpu_ready.
    while (t < 100) tick();
    rand_access(-1);

    for (int i = 0; i < 6; i++)
      run_access(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].dout, vecs[i].e_addr,
                 vecs[i].e_ds, vecs[i].e_din, vecs[i].e_rd, 3, 1'b0);

    // Continuously held request: two reads in alternate slots.
    run_access(1'b0, 25'h0000010, 8'h11, 16'hBEEF, 24'h000008, 2'b01, 16'h1111, 8'hEF, 3, 1'b1);
    run_access(1'b0, 25'h0000011, 8'h22, 16'h1357, 24'h000008, 2'b10, 16'h2222, 8'h13, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 9)) tick();
      rand_access(-1);
    end
    check_stats("stat");

    // Reset in the middle of a write slot aborts it without an ack.
    for (int i = 0; i < 8 && (t % 8) != 3; i++) tick();
    cpu_we = 1'b1; cpu_addr = 25'h0000123; cpu_wdata = 8'h5A; cpu_req = 1'b1;
    st = t + 8 - (t % 8);
    while (t < st + 3) tick();
    check("busy_we", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_oe", 32'(mem_oe), 32'd0);
    check("abort_init", 32'(mem_init), 32'd1);
    check("abort_sdt", 32'(sdt), 32'd0);
    n_rd = 0; n_wr = 0; last_rd = 8'h00;
    check_stats("abort_stat");
    cpu_req = 1'b0;
    @(negedge clk_hi);
    @(negedge clk_hi);
    rst = 1'b0;
    t = 0;
    t_idle = READY_T;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("abort_no_ack", 32'(cpu_ack), 32'd0);
      check("abort_idle_bus", 32'({mem_oe, mem_we}), 32'd0);
    end
    check("abort_rdata", 32'(cpu_rdata), 32'd0);

    while (t < 290) tick();
    for (int i = 0; i < 3; i++) begin
      logic [24:0] a;
      logic [15:0] d;
      a = 25'($urandom);
      d = 16'($urandom);
      run_access(1'b0, a, 8'h00, d, m_addr(a), m_ds(a), 16'h0000, m_rd(a, d), -1, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      logic [24:0] a;
      logic [7:0]  w;
      a = 25'($urandom);
      w = 8'($urandom);
      run_access(1'b1, a, w, 16'h0000, m_addr(a), m_ds(a), {w, w}, 8'h00, -1, 1'b0);
    end
    check_stats("stat_3r2w");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
